// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the MIPS multicycle control path.
// Holds the opcode values decoded by the main controller, the aluop
// encodings shared with the ALU function decoder, and the 4-bit state
// encoding of the main controller FSM.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // States that hold a memory access open until mem_ready.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory wait watchdog.
// Counts consecutive cycles a memory state is held without mem_ready and
// flags a timeout when the count reaches WAIT_LIMIT.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   active      : controller is in a memory state this cycle
//   mem_ready   : memory completes the access this cycle
//   timeout     : count reached WAIT_LIMIT with no mem_ready (combinational)
module mem_wait_ctr #(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic active,
    input  logic mem_ready,
    output logic timeout
);

    logic [WAIT_W-1:0] count;

    // A mem_ready on the limit cycle wins: the access completes normally.
    assign timeout = active & ~mem_ready & (count == WAIT_W'(WAIT_LIMIT));

    // Counter is zero whenever no access is stalling, so every memory state
    // is entered with a cleared count.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (active && !mem_ready && !timeout) begin
            count <= count + 1'b1;
        end else begin
            count <= '0;
        end
    end

endmodule

// File: rtl/mc_main_ctrl.sv
// Multicycle main controller for the MIPS core.
// Sequences FETCH/DECODE/EXECUTE/MEM/WB, drives datapath enables/selects
// and the 2-bit aluop, handshakes with a variable-latency memory and
// watchdogs stalled accesses.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   op, zero, mem_ready   : opcode, ALU zero flag, memory completion
//   mem_req, memwrite     : memory request / write strobe
//   iord, irwrite, pcen   : address select, IR load, PC load
//   regwrite, regdst, memtoreg : register file controls
//   alusrca, alusrcb, pcsrc, aluop : datapath selects
//   illegal_op, mem_timeout : one-cycle error pulses
module mc_main_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int WAIT_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       memwrite,
    output logic       iord,
    output logic       irwrite,
    output logic       pcen,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic       illegal_op,
    output logic       mem_timeout
);

    state_t state;
    logic   timeout;
    logic   pcwrite;
    logic   branch;

    mem_wait_ctr #(
        .WAIT_LIMIT (WAIT_LIMIT),
        .WAIT_W     (WAIT_W)
    ) u_wait (
        .clk       (clk),
        .reset     (reset),
        .active    (is_mem_state(state)),
        .mem_ready (mem_ready),
        .timeout   (timeout)
    );

    // On timeout the access is abandoned and the instruction refetched.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            case (state)
                S_FETCH: begin
                    if (mem_ready)    state <= S_DECODE;
                    else if (timeout) state <= S_FETCH;
                end
                S_DECODE: begin
                    case (op)
                        OP_LW, OP_SW: state <= S_MEMADR;
                        OP_RTYPE:     state <= S_EXECUTE;
                        OP_BEQ:       state <= S_BRANCH;
                        OP_ADDI:      state <= S_ADDIEX;
                        OP_J:         state <= S_JUMP;
                        default:      state <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state <= (op == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (mem_ready)    state <= S_MEMWB;
                    else if (timeout) state <= S_FETCH;
                end
                S_MEMWR: begin
                    if (mem_ready || timeout) state <= S_FETCH;
                end
                S_EXECUTE: state <= S_ALUWB;
                S_ADDIEX:  state <= S_ADDIWB;
                default:   state <= S_FETCH;
            endcase
        end
    end

    // Moore decode of state; FETCH enables and pcen also depend on
    // mem_ready / zero. Everything reads 0 while reset is held.
    always_comb begin
        mem_req     = 1'b0;
        memwrite    = 1'b0;
        iord        = 1'b0;
        irwrite     = 1'b0;
        pcwrite     = 1'b0;
        branch      = 1'b0;
        regwrite    = 1'b0;
        regdst      = 1'b0;
        memtoreg    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        pcsrc       = 2'b00;
        aluop       = ALUOP_ADD;
        illegal_op  = 1'b0;
        mem_timeout = 1'b0;
        if (!reset) begin
            mem_timeout = timeout;
            case (state)
                S_FETCH: begin
                    mem_req = 1'b1;
                    alusrcb = 2'b01;
                    irwrite = mem_ready;
                    pcwrite = mem_ready;
                end
                S_DECODE: begin
                    alusrcb = 2'b11;
                    case (op)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                        default: illegal_op = 1'b1;
                    endcase
                end
                S_MEMADR, S_ADDIEX: begin
                    alusrca = 1'b1;
                    alusrcb = 2'b10;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    regwrite = 1'b1;
                    memtoreg = 1'b1;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    iord     = 1'b1;
                    memwrite = ~timeout;
                end
                S_EXECUTE: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_FUNCT;
                end
                S_ALUWB: begin
                    regwrite = 1'b1;
                    regdst   = 1'b1;
                end
                S_BRANCH: begin
                    alusrca = 1'b1;
                    aluop   = ALUOP_SUB;
                    pcsrc   = 2'b01;
                    branch  = 1'b1;
                end
                S_ADDIWB: regwrite = 1'b1;
                S_JUMP: begin
                    pcsrc   = 2'b10;
                    pcwrite = 1'b1;
                end
                default: ;
            endcase
        end
        pcen = pcwrite | (branch & zero);
    end

endmodule

// File: tb/tb_mc_main_ctrl.sv
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg;
    logic       alusrca, illegal_op, mem_timeout;
    logic [1:0] alusrcb, pcsrc, aluop;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mc_main_ctrl #(.WAIT_LIMIT(4), .WAIT_W(3)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
        .pcen(pcen), .regwrite(regwrite), .regdst(regdst), .memtoreg(memtoreg),
        .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout)
    );

    // Output bundle, MSB first:
    // mem_req memwrite iord irwrite pcen regwrite regdst memtoreg alusrca
    // alusrcb[1:0] pcsrc[1:0] aluop[1:0] illegal_op mem_timeout
    logic [16:0] outs;
    assign outs = {mem_req, memwrite, iord, irwrite, pcen, regwrite, regdst, memtoreg,
                   alusrca, alusrcb, pcsrc, aluop, illegal_op, mem_timeout};

    function automatic logic [16:0] v(input logic mr, mw, io, ir, pc, rw, rd, mt, sa,
                                      input logic [1:0] sb, ps, ao,
                                      input logic il, to);
        return {mr, mw, io, ir, pc, rw, rd, mt, sa, sb, ps, ao, il, to};
    endfunction

    logic [16:0] E_IDLE, E_F_RDY, E_F_WAIT, E_DEC, E_DEC_ILL, E_EXEC, E_ALUWB, E_MEMADR;
    logic [16:0] E_MEMRD, E_MEMWB, E_MEMWR, E_WR_TO, E_BR_Z, E_BR_NZ, E_ADDIWB, E_JUMP;

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Inputs are set at a negedge; sample 1 ns later, then move to the next negedge.
    task automatic cyc(input string tag, input logic [16:0] exp);
        #1;
        check(tag, outs, exp);
        @(negedge clk);
    endtask

    initial begin
        E_IDLE    = v(0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        E_F_RDY   = v(1,0,0,1,1,0,0,0,0,2'b01,2'b00,2'b00,0,0);
        E_F_WAIT  = v(1,0,0,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
        E_DEC     = v(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
        E_DEC_ILL = v(0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,1,0);
        E_EXEC    = v(0,0,0,0,0,0,0,0,1,2'b00,2'b00,2'b10,0,0);
        E_ALUWB   = v(0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00,0,0);
        E_MEMADR  = v(0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
        E_MEMRD   = v(1,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        E_MEMWB   = v(0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0,0);
        E_MEMWR   = v(1,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
        E_WR_TO   = v(1,0,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1);
        E_BR_Z    = v(0,0,0,0,1,0,0,0,1,2'b00,2'b01,2'b01,0,0);
        E_BR_NZ   = v(0,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0,0);
        E_ADDIWB  = v(0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00,0,0);
        E_JUMP    = v(0,0,0,0,1,0,0,0,0,2'b00,2'b10,2'b00,0,0);

        reset = 1'b1; op = 6'b000000; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        cyc("rst0", E_IDLE);
        cyc("rst1", E_IDLE);
        cyc("rst2", E_IDLE);
        reset = 1'b0;

        // R-type, zero-wait: 4 cycles
        cyc("r_fetch", E_F_RDY);
        cyc("r_decode", E_DEC);
        cyc("r_exec", E_EXEC);
        cyc("r_aluwb", E_ALUWB);

        // lw with two wait cycles in MEMRD: 7 cycles
        op = 6'b100011;
        cyc("lw_fetch", E_F_RDY);
        cyc("lw_decode", E_DEC);
        cyc("lw_memadr", E_MEMADR);
        mem_ready = 1'b0;
        cyc("lw_memrd_w0", E_MEMRD);
        cyc("lw_memrd_w1", E_MEMRD);
        mem_ready = 1'b1;
        cyc("lw_memrd_rdy", E_MEMRD);
        cyc("lw_memwb", E_MEMWB);

        // beq taken then not taken
        op = 6'b000100; zero = 1'b1;
        cyc("beq1_fetch", E_F_RDY);
        cyc("beq1_decode", E_DEC);
        cyc("beq1_branch", E_BR_Z);
        zero = 1'b0;
        cyc("beq0_fetch", E_F_RDY);
        cyc("beq0_decode", E_DEC);
        cyc("beq0_branch", E_BR_NZ);

        // unsupported opcode
        op = 6'b111111;
        cyc("ill_fetch", E_F_RDY);
        cyc("ill_decode", E_DEC_ILL);
        cyc("ill_refetch", E_F_RDY);
        cyc("ill_decode2", E_DEC_ILL);

        // addi
        op = 6'b001000;
        cyc("addi_fetch", E_F_RDY);
        cyc("addi_decode", E_DEC);
        cyc("addi_ex", E_MEMADR);
        cyc("addi_wb", E_ADDIWB);

        // sw stalled to timeout (WAIT_LIMIT=4): pulse on 5th wait cycle
        op = 6'b101011;
        cyc("swto_fetch", E_F_RDY);
        cyc("swto_decode", E_DEC);
        cyc("swto_memadr", E_MEMADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc($sformatf("swto_wait%0d", i), E_MEMWR);
        cyc("swto_timeout", E_WR_TO);
        cyc("swto_refetch_wait", E_F_WAIT);
        mem_ready = 1'b1;

        // sw with mem_ready arriving on the limit cycle: normal completion
        cyc("swok_fetch", E_F_RDY);
        cyc("swok_decode", E_DEC);
        cyc("swok_memadr", E_MEMADR);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) cyc($sformatf("swok_wait%0d", i), E_MEMWR);
        mem_ready = 1'b1;
        cyc("swok_limit_rdy", E_MEMWR);

        // jump
        op = 6'b000010;
        cyc("j_fetch", E_F_RDY);
        cyc("j_decode", E_DEC);
        cyc("j_jump", E_JUMP);

        // reset asserted mid-access in MEMRD
        op = 6'b100011;
        cyc("rmid_fetch", E_F_RDY);
        cyc("rmid_decode", E_DEC);
        cyc("rmid_memadr", E_MEMADR);
        mem_ready = 1'b0;
        cyc("rmid_memrd", E_MEMRD);
        reset = 1'b1;
        cyc("rmid_reset", E_IDLE);
        reset = 1'b0;
        cyc("rmid_fetch_after", E_F_WAIT);
        mem_ready = 1'b1;
        cyc("rmid_fetch_rdy", E_F_RDY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
